// File: rtl/fp32_mul_round_pack.sv
// Float32 multiply back end: normalizes the 48-bit significand product, rounds to
// nearest-even, saturates/flushes out-of-range exponents and packs the result.
module fp32_mul_round_pack #(
   parameter int EXP_W = 10
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [47:0]      i_product,
   input  logic             i_sign,
   input  logic [EXP_W-1:0] i_exp_sum,
   input  logic             i_is_nan,
   input  logic             i_is_inf,
   input  logic             i_is_zero,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [31:0]      o_data,
   output logic             o_overflow,
   output logic             o_underflow,
   output logic             o_inexact
);

   localparam int XW = EXP_W + 1;
   localparam logic signed [XW-1:0] EXP_ZERO = {XW{1'b0}};
   localparam logic signed [XW-1:0] EXP_ONE  = {{EXP_W{1'b0}}, 1'b1};
   localparam logic signed [XW-1:0] EXP_TOP  = XW'(9'd255);

   logic                 s1_valid_r;
   logic                 s2_valid_r;
   logic                 s1_adv_s;
   logic                 s2_adv_s;

   logic signed [XW-1:0] exp_ext_s;
   logic [22:0]          norm_mant_s;
   logic                 norm_guard_s;
   logic                 norm_sticky_s;
   logic signed [XW-1:0] norm_exp_s;

   logic [22:0]          s1_mant_r;
   logic                 s1_guard_r;
   logic                 s1_sticky_r;
   logic signed [XW-1:0] s1_exp_r;
   logic                 s1_sign_r;
   logic                 s1_nan_r;
   logic                 s1_inf_r;
   logic                 s1_zero_r;

   logic                 round_up_s;
   logic [23:0]          mant_sum_s;
   logic signed [XW-1:0] exp_final_s;
   logic [31:0]          pack_data_s;
   logic                 pack_ov_s;
   logic                 pack_uf_s;
   logic                 pack_inx_s;

   logic [31:0]          s2_data_r;
   logic                 s2_ov_r;
   logic                 s2_uf_r;
   logic                 s2_inx_r;

   // A stage may take new data when it is empty or its content moves on this cycle.
   assign s2_adv_s = !s2_valid_r | i_ready;
   assign s1_adv_s = !s1_valid_r | s2_adv_s;
   assign o_ready  = s1_adv_s;

   // Exponent widened by one bit so the +1 adjustments can never wrap.
   assign exp_ext_s = {i_exp_sum[EXP_W-1], i_exp_sum};

   // Normalize: the product of two 1.x significands lies in [1,4).
   always_comb begin
      norm_mant_s   = i_product[45:23];
      norm_guard_s  = i_product[22];
      norm_sticky_s = |i_product[21:0];
      norm_exp_s    = exp_ext_s;
      if (i_product[47]) begin
         norm_mant_s   = i_product[46:24];
         norm_guard_s  = i_product[23];
         norm_sticky_s = |i_product[22:0];
         norm_exp_s    = exp_ext_s + EXP_ONE;
      end else begin
         norm_mant_s   = i_product[45:23];
         norm_guard_s  = i_product[22];
         norm_sticky_s = |i_product[21:0];
         norm_exp_s    = exp_ext_s;
      end
   end

   // Stage 1 register: normalized fields plus carried sign and special flags.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid_r  <= 1'b0;
         s1_mant_r   <= 23'h0;
         s1_guard_r  <= 1'b0;
         s1_sticky_r <= 1'b0;
         s1_exp_r    <= EXP_ZERO;
         s1_sign_r   <= 1'b0;
         s1_nan_r    <= 1'b0;
         s1_inf_r    <= 1'b0;
         s1_zero_r   <= 1'b0;
      end else if (s1_adv_s) begin
         s1_valid_r <= i_valid;
         if (i_valid) begin
            s1_mant_r   <= norm_mant_s;
            s1_guard_r  <= norm_guard_s;
            s1_sticky_r <= norm_sticky_s;
            s1_exp_r    <= norm_exp_s;
            s1_sign_r   <= i_sign;
            s1_nan_r    <= i_is_nan;
            s1_inf_r    <= i_is_inf;
            s1_zero_r   <= i_is_zero;
         end
      end
   end

   // Round to nearest-even; a mantissa carry-out leaves zero fraction and bumps the exponent.
   assign round_up_s  = s1_guard_r & (s1_sticky_r | s1_mant_r[0]);
   assign mant_sum_s  = {1'b0, s1_mant_r} + {23'h0, round_up_s};
   assign exp_final_s = s1_exp_r + (mant_sum_s[23] ? EXP_ONE : EXP_ZERO);

   // Result selection: specials first, then overflow, flush-to-zero, normal.
   always_comb begin
      pack_data_s = 32'h0;
      pack_ov_s   = 1'b0;
      pack_uf_s   = 1'b0;
      pack_inx_s  = 1'b0;
      if (s1_nan_r) begin
         pack_data_s = 32'h7FC0_0000;
      end else if (s1_inf_r) begin
         pack_data_s = {s1_sign_r, 8'hFF, 23'h0};
      end else if (s1_zero_r) begin
         pack_data_s = {s1_sign_r, 31'h0};
      end else if (exp_final_s >= EXP_TOP) begin
         pack_data_s = {s1_sign_r, 8'hFF, 23'h0};
         pack_ov_s   = 1'b1;
         pack_inx_s  = 1'b1;
      end else if (exp_final_s <= EXP_ZERO) begin
         pack_data_s = {s1_sign_r, 31'h0};
         pack_uf_s   = 1'b1;
         pack_inx_s  = 1'b1;
      end else begin
         pack_data_s = {s1_sign_r, exp_final_s[7:0], mant_sum_s[22:0]};
         pack_inx_s  = s1_guard_r | s1_sticky_r;
      end
   end

   // Stage 2 register drives the outputs directly and holds them while stalled.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s2_valid_r <= 1'b0;
         s2_data_r  <= 32'h0;
         s2_ov_r    <= 1'b0;
         s2_uf_r    <= 1'b0;
         s2_inx_r   <= 1'b0;
      end else if (s2_adv_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_data_r <= pack_data_s;
            s2_ov_r   <= pack_ov_s;
            s2_uf_r   <= pack_uf_s;
            s2_inx_r  <= pack_inx_s;
         end
      end
   end

   assign o_valid     = s2_valid_r;
   assign o_data      = s2_data_r;
   assign o_overflow  = s2_ov_r;
   assign o_underflow = s2_uf_r;
   assign o_inexact   = s2_inx_r;

endmodule

// File: tb/tb_fp32_mul_round_pack.sv
// Self-checking bench for fp32_mul_round_pack: directed vectors, backpressure,
// mid-stream reset and a randomized stream against an arithmetic reference model.
module tb_fp32_mul_round_pack;

   logic               i_clk = 1'b0;
   logic               i_rst;
   logic               i_valid;
   logic               o_ready;
   logic [47:0]        i_product;
   logic               i_sign;
   logic signed [9:0]  i_exp_sum;
   logic               i_is_nan;
   logic               i_is_inf;
   logic               i_is_zero;
   logic               o_valid;
   logic               i_ready;
   logic [31:0]        o_data;
   logic               o_overflow;
   logic               o_underflow;
   logic               o_inexact;

   int checks   = 0;
   int failures = 0;
   logic [34:0] exp_q[$];

   fp32_mul_round_pack #(.EXP_W(10)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_product(i_product), .i_sign(i_sign), .i_exp_sum(i_exp_sum),
      .i_is_nan(i_is_nan), .i_is_inf(i_is_inf), .i_is_zero(i_is_zero),
      .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
      .o_overflow(o_overflow), .o_underflow(o_underflow), .o_inexact(o_inexact)
   );

   always #5 i_clk = ~i_clk;

   // Reference: integer division of the product with round-half-even, then range limits.
   // Returns {data[31:0], overflow, underflow, inexact}.
   function automatic logic [34:0] ref_model(input logic [47:0] p, input logic s,
                                             input logic signed [9:0] es_in,
                                             input logic nan, input logic inf, input logic zero);
      longint unsigned prod, m, rem, half;
      int sh, e;
      logic inx;
      if (nan)  return {32'h7FC0_0000, 3'b000};
      if (inf)  return {s, 8'hFF, 23'h0, 3'b000};
      if (zero) return {s, 31'h0, 3'b000};
      prod = 64'(p);
      sh   = p[47] ? 24 : 23;
      e    = int'(es_in) + (p[47] ? 1 : 0);
      m    = prod >> sh;
      rem  = prod & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 64'd0);
      if (rem > half || (rem == half && m[0])) m = m + 64'd1;
      if (m == (64'd1 << 24)) begin
         m = m >> 1;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0, 3'b101};
      if (e <= 0)   return {s, 31'h0, 3'b011};
      return {s, e[7:0], m[22:0], 2'b00, inx};
   endfunction

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic new_bundle(input int special_pct);
      logic [47:0] p;
      int e;
      p[47:32] = 16'($urandom());
      p[31:0]  = $urandom();
      if ($urandom_range(1, 0) == 1) p[47] = 1'b1;
      else p[47:46] = 2'b01;
      case ($urandom_range(3, 0))
         0: p[22:0] = 23'h40_0000;
         1: p[23:0] = 24'h80_0000;
         default: ;
      endcase
      case ($urandom_range(2, 0))
         0: e = int'($urandom_range(8, 0)) + 250;
         1: e = int'($urandom_range(4, 0)) - 2;
         default: e = int'($urandom_range(635, 0)) - 254;
      endcase
      i_product = p;
      i_exp_sum = e[9:0];
      i_sign    = 1'($urandom());
      i_is_nan  = ($urandom_range(99, 0) < special_pct / 3);
      i_is_inf  = ($urandom_range(99, 0) < special_pct / 3);
      i_is_zero = ($urandom_range(99, 0) < special_pct / 3);
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
      i_product = 48'h0; i_sign = 1'b0; i_exp_sum = 10'sd0;
      i_is_nan = 1'b0; i_is_inf = 1'b0; i_is_zero = 1'b0;
      step(); step();
      checks++;
      if ({o_valid, o_data, o_overflow, o_underflow, o_inexact} !== 36'h0) begin
         failures++;
         $display("FAIL reset_outputs: got valid=%b data=%h flags=%b%b%b, need all zero",
                  o_valid, o_data, o_overflow, o_underflow, o_inexact);
      end
      i_rst = 1'b0;
      #1;
      checks++;
      if (o_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: got o_ready=%b, need 1", o_ready);
      end
      step();
   endtask

   task automatic test_directed();
      logic [47:0]       prod_t [14] = '{48'h4000_0000_0000, 48'h9000_0000_0000, 48'h4000_00C0_0000,
                                         48'h4000_0040_0000, 48'h7FFF_FFC0_0000, 48'h8000_0000_0000,
                                         48'h4000_0000_0000, 48'h4000_0000_0000, 48'h4000_0000_0000,
                                         48'h4000_0000_0000, 48'h8000_0000_0000, 48'h4000_0000_0000,
                                         48'hC123_4567_89AB, 48'h7FFF_FFC0_0000};
      logic signed [9:0] exp_t  [14] = '{10'sd127, 10'sd127, 10'sd127, 10'sd127, 10'sd127, 10'sd254,
                                         10'sd0, 10'sd127, 10'sd127, -10'sd254, 10'sd253, 10'sd1,
                                         10'sd40, 10'sd254};
      logic [3:0]        snzi_t [14] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000,
                                         4'b0000, 4'b0110, 4'b1001, 4'b0000, 4'b0000, 4'b0000,
                                         4'b0010, 4'b0000};
      logic [34:0]       want_t [14] = '{{32'h3F80_0000, 3'b000}, {32'h4010_0000, 3'b000},
                                         {32'h3F80_0002, 3'b001}, {32'h3F80_0000, 3'b001},
                                         {32'h4000_0000, 3'b001}, {32'hFF80_0000, 3'b101},
                                         {32'h0000_0000, 3'b011}, {32'h7FC0_0000, 3'b000},
                                         {32'h8000_0000, 3'b000}, {32'h0000_0000, 3'b011},
                                         {32'h7F00_0000, 3'b000}, {32'h0080_0000, 3'b000},
                                         {32'h7F80_0000, 3'b000}, {32'h7F80_0000, 3'b101}};
      logic [34:0] got;
      for (int k = 0; k < 14; k++) begin
         i_product = prod_t[k]; i_exp_sum = exp_t[k];
         {i_sign, i_is_nan, i_is_inf, i_is_zero} = snzi_t[k];
         i_valid = 1'b1; i_ready = 1'b1;
         step();
         i_valid = 1'b0;
         checks++;
         if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_early[%0d]: got o_valid=%b one cycle after accept, need 0", k, o_valid);
         end
         step();
         got = {o_data, o_overflow, o_underflow, o_inexact};
         checks++;
         if (o_valid !== 1'b1 || got !== want_t[k]) begin
            failures++;
            $display("FAIL directed[%0d]: got valid=%b data=%h ovf/unf/inx=%b, need valid=1 data=%h ovf/unf/inx=%b",
                     k, o_valid, o_data, got[2:0], want_t[k][34:3], want_t[k][2:0]);
         end
      end
      step();
   endtask

   task automatic test_backpressure();
      int sent = 0, delivered = 0, occ = 0, stall_left = 0, cyc = 0;
      bit first_seen = 0, saw_not_ready = 0, hold = 0, in_x, out_x;
      logic [35:0] held;
      logic [34:0] want;
      exp_q.delete();
      new_bundle(0);
      while (delivered < 4 && cyc < 40) begin
         if (o_valid && !first_seen) begin
            first_seen = 1; stall_left = 3;
         end
         i_valid = (sent < 4);
         i_ready = (stall_left == 0);
         #2;
         checks++;
         if (o_ready !== ((occ < 2) || i_ready)) begin
            failures++;
            $display("FAIL bp_ready: got o_ready=%b, need %b (occupancy %0d)", o_ready, (occ < 2) || i_ready, occ);
         end
         if (o_ready === 1'b0) saw_not_ready = 1;
         if (hold) begin
            checks++;
            if ({o_valid, o_data, o_overflow, o_underflow, o_inexact} !== held) begin
               failures++;
               $display("FAIL bp_stable: got %h, need held %h", {o_valid, o_data, o_overflow, o_underflow, o_inexact}, held);
            end
         end
         in_x  = i_valid & o_ready;
         out_x = o_valid & i_ready;
         if (out_x) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
            checks++;
            if ({o_data, o_overflow, o_underflow, o_inexact} !== want) begin
               failures++;
               $display("FAIL bp_order[%0d]: got %h, need %h", delivered, {o_data, o_overflow, o_underflow, o_inexact}, want);
            end
            delivered++;
         end
         hold = o_valid & !i_ready;
         held = {o_valid, o_data, o_overflow, o_underflow, o_inexact};
         if (in_x) begin
            exp_q.push_back(ref_model(i_product, i_sign, i_exp_sum, i_is_nan, i_is_inf, i_is_zero));
            sent++;
         end
         occ = occ + int'(in_x) - int'(out_x);
         if (stall_left > 0) stall_left--;
         step();
         if (in_x) new_bundle(0);
         cyc++;
      end
      checks++;
      if (delivered != 4 || saw_not_ready != 1) begin
         failures++;
         $display("FAIL bp_summary: got delivered=%0d saw_not_ready=%0d, need 4 and 1", delivered, saw_not_ready);
      end
      i_valid = 1'b0; i_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_duplicate: got o_valid=%b after all delivered, need 0", o_valid);
         end
      end
   endtask

   task automatic test_reset_midstream();
      i_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         new_bundle(0);
         i_valid = 1'b1;
         step();
      end
      i_rst = 1'b1; i_ready = 1'b1;
      step();
      checks++;
      if (o_valid !== 1'b0 || o_data !== 32'h0) begin
         failures++;
         $display("FAIL midreset_clear: got valid=%b data=%h, need 0 and 0", o_valid, o_data);
      end
      i_rst = 1'b0; i_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         checks++;
         if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_stale: got o_valid=%b at cycle %0d after reset, need 0", o_valid, k);
         end
      end
   endtask

   task automatic test_random_stream();
      int occ = 0, cyc = 0, delivered = 0;
      bit hold = 0, in_x, out_x, drain;
      logic [35:0] held;
      logic [34:0] want;
      exp_q.delete();
      new_bundle(30);
      while (cyc < 400) begin
         drain   = (cyc >= 300);
         i_valid = !drain && ($urandom_range(9, 0) < 7);
         i_ready = drain || ($urandom_range(9, 0) < 7);
         #2;
         checks++;
         if (o_ready !== ((occ < 2) || i_ready)) begin
            failures++;
            $display("FAIL rnd_ready: got o_ready=%b, need %b (occupancy %0d)", o_ready, (occ < 2) || i_ready, occ);
         end
         if (hold) begin
            checks++;
            if ({o_valid, o_data, o_overflow, o_underflow, o_inexact} !== held) begin
               failures++;
               $display("FAIL rnd_stable: got %h, need held %h", {o_valid, o_data, o_overflow, o_underflow, o_inexact}, held);
            end
         end
         in_x  = i_valid & o_ready;
         out_x = o_valid & i_ready;
         if (out_x) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
            checks++;
            if ({o_data, o_overflow, o_underflow, o_inexact} !== want) begin
               failures++;
               $display("FAIL rnd_result[%0d]: got %h, need %h", delivered, {o_data, o_overflow, o_underflow, o_inexact}, want);
            end
            delivered++;
         end
         hold = o_valid & !i_ready;
         held = {o_valid, o_data, o_overflow, o_underflow, o_inexact};
         if (in_x) exp_q.push_back(ref_model(i_product, i_sign, i_exp_sum, i_is_nan, i_is_inf, i_is_zero));
         occ = occ + int'(in_x) - int'(out_x);
         step();
         if (in_x) new_bundle(30);
         cyc++;
      end
      checks++;
      if (exp_q.size() != 0 || delivered < 50) begin
         failures++;
         $display("FAIL rnd_drain: got %0d undelivered, %0d delivered, need 0 undelivered and at least 50 delivered",
                  exp_q.size(), delivered);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_midstream();
      test_random_stream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fp32_mul_round_pack.md
Name: fp32_mul_round_pack

Overview:
- Downstream stage of the 24-bit significand multiplier in the float32 multiply datapath.
- Consumes the 48-bit significand product, the pre-computed sign and biased exponent sum, and the special-case flags.
- Normalizes, rounds to nearest-even, detects overflow/underflow and packs the IEEE-754 single-precision result.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- EXP_W, 10, width of the signed exponent-sum input (two's complement; must cover -254..+381).

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset; synchronous, active-high.
- i_valid  input  1  upstream operand bundle valid.
- o_ready  output  1  block can accept a bundle this cycle.
- i_product  input  48  unsigned significand product, from two 1.23 significands.
- i_sign  input  1  result sign, sign_a XOR sign_b.
- i_exp_sum  input  EXP_W  signed value ea + eb - 127 (biased exponent before normalization).
- i_is_nan  input  1  result is NaN (any NaN operand, or 0 x inf).
- i_is_inf  input  1  result is infinite.
- i_is_zero  input  1  result is exact zero.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_data  output  32  packed float32 result.
- o_overflow  output  1  result overflowed to infinity.
- o_underflow  output  1  result flushed to zero.
- o_inexact  output  1  rounding, overflow or flush discarded nonzero bits.

Behaviour:
- Reset (i_rst=1 at a rising edge): both stage-valid bits clear; o_valid=0; o_data=0; o_overflow=0; o_underflow=0; o_inexact=0. Any in-flight data is discarded. o_ready=1 in the cycle after reset.
- Handshake:
  - Input transfer when i_valid & o_ready. Output transfer when o_valid & i_ready.
  - While o_valid=1 and i_ready=0, o_data and the flags stay stable.
  - Each stage advances when it is empty or the next stage advances.
  - o_ready = !s1_valid | !s2_valid | i_ready (combinational).
  - Full throughput: one result per cycle.
- Latency: an accepted input appears on o_valid exactly 2 cycles later, absent backpressure.
- Stage 1 (normalize), registered:
  - If i_product[47]=1: mant=i_product[46:24], guard=i_product[23], sticky=OR(i_product[22:0]), exp=i_exp_sum+1.
  - Else: mant=i_product[45:23], guard=i_product[22], sticky=OR(i_product[21:0]), exp=i_exp_sum.
  - i_product[47:46]=00 is not produced for non-special inputs and is don't-care.
  - Sign and special flags are carried along.
- Stage 2 (round/pack), registered to outputs:
  - round_up = guard & (sticky | mant[0]).
  - mant_r = mant + round_up. On carry-out (mant=0x7FFFFF), mant_r=0 and exp+1.
  - exp_final >= 255: o_data={sign,8'hFF,23'h0}, o_overflow=1, o_inexact=1.
  - exp_final <= 0: o_data={sign,31'h0}, o_underflow=1, o_inexact=1. No subnormals are produced.
  - Otherwise: o_data={sign,exp_final[7:0],mant_r}, o_inexact=guard|sticky.
- Special priority: nan > inf > zero > normal path.
  - NaN: o_data=32'h7FC00000.
  - Inf: {sign,8'hFF,0}.
  - Zero: {sign,31'h0}.
  - For all specials, the overflow, underflow and inexact flags are 0.
- Exponent arithmetic is done in EXP_W+1 bits signed, so no internal wrap occurs.
- Reset asserted mid-stream overrides any simultaneous transfer. No result is emitted for bundles accepted before reset.

Test Plan:
- 1.0 x 1.0: i_product=0x400000000000, i_exp_sum=127, sign 0 -> o_data=0x3F800000 two cycles later, all flags 0.
- 1.5 x 1.5: i_product=0x900000000000, i_exp_sum=127 -> 0x40100000, exact.
- Rounding:
  - 0x400000C00000, exp_sum=127 -> 0x3F800002, inexact=1 (tie rounds to even).
  - 0x400000400000 -> 0x3F800000, inexact=1.
  - 0x7FFFFFC00000 -> 0x40000000 (mantissa carry bumps exponent).
- Range limits:
  - i_product=0x800000000000, i_exp_sum=254, sign 1 -> 0xFF800000, overflow=1, inexact=1.
  - i_product=0x400000000000, i_exp_sum=0 -> 0x00000000, underflow=1, inexact=1.
- Specials: i_is_nan=1 with i_is_inf=1 -> 0x7FC00000, flags 0. i_is_zero=1, sign 1 -> 0x80000000.
- Backpressure:
  - Stream 4 back-to-back inputs and hold i_ready=0 for 3 cycles after the first o_valid.
  - Required: o_data stable while stalled; o_ready=0 once both stages are full.
  - Required: all 4 results delivered in order, none lost or duplicated.
  - Then assert i_rst mid-stream: o_valid=0 on the next cycle and no stale results appear afterwards.
